// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified RAM between instruction
// fetch (read-only) and the MEM stage (load/store). Each access is sequenced
// IDLE -> ACCESS -> (WAIT) -> RESP, and per-requester stall requests hold the
// pipeline while an access is outstanding.
// Optional feature: define MEM_ARB_FAIR_EN to add a starve counter that
// hands IF the port after STARVE_LIMIT consecutive MEM grants.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int RAM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_valid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic [3:0]        mem_be_i,
   output logic              mem_valid_o,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              ram_ce_o,
   output logic              ram_we_o,
   output logic [3:0]        ram_be_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic              stallreq_if_o,
   output logic              stallreq_mem_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_MEM  = 2'd2;

   // Parameter sanity: the wait counter is 3 bits, the starve counter 4 bits.
   if (RAM_LATENCY < 1 || RAM_LATENCY > 7) begin : g_bad_latency
      $error("mem_port_arbiter: RAM_LATENCY must be 1..7");
   end
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
   end

   logic [1:0]        state;
   logic [1:0]        owner;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;
   logic [DATA_W-1:0] lat_wdata;
   logic [3:0]        lat_be;
   logic [2:0]        cnt;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] mem_rdata_q;
   logic              grant_mem;

`ifdef MEM_ARB_FAIR_EN
   localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);
   logic [3:0] starve_cnt;

   // MEM normally wins a tie; IF takes the port once MEM has starved it long enough.
   always_comb begin
      grant_mem = mem_req_i & ~(if_req_i & (starve_cnt == STARVE_LIM4));
   end

   // Count MEM grants issued while IF is waiting; any other grant clears the run.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_cnt <= 4'd0;
      end else if (state == S_IDLE && (if_req_i || mem_req_i)) begin
         starve_cnt <= (grant_mem && if_req_i) ? starve_cnt + 4'd1 : 4'd0;
      end
   end
`else
   // Strict priority: MEM always wins a tie.
   always_comb begin
      grant_mem = mem_req_i;
   end
`endif

   // Access sequencer: latch the winner, strobe the RAM, wait out latency, respond.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         owner       <= OWN_NONE;
         lat_addr    <= '0;
         lat_we      <= 1'b0;
         lat_wdata   <= '0;
         lat_be      <= 4'd0;
         cnt         <= 3'd0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register updates from
         // the pre-edge values, independent of statement order.
         case (state)
            S_IDLE: begin
               if (if_req_i || mem_req_i) begin
                  state <= S_ACCESS;
                  if (grant_mem) begin
                     owner     <= OWN_MEM;
                     lat_addr  <= mem_addr_i;
                     lat_we    <= mem_we_i;
                     lat_wdata <= mem_wdata_i;
                     lat_be    <= mem_be_i;
                  end else begin
                     owner     <= OWN_IF;
                     lat_addr  <= if_addr_i;
                     lat_we    <= 1'b0;
                     lat_wdata <= '0;
                     lat_be    <= 4'd0;
                  end
               end
            end
            S_ACCESS: begin
               if (lat_we) begin
                  // Stores report zero load data on their completion pulse.
                  mem_rdata_q <= '0;
                  state       <= S_RESP;
               end else begin
                  cnt   <= 3'(RAM_LATENCY - 1);
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 3'd0) begin
                  if (owner == OWN_MEM) begin
                     mem_rdata_q <= ram_rdata_i;
                  end else begin
                     if_rdata_q <= ram_rdata_i;
                  end
                  state <= S_RESP;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            default: begin
               // RESP: the owner's request is still high but is not re-arbitrated.
               state <= S_IDLE;
               owner <= OWN_NONE;
            end
         endcase
      end
   end

   // RAM command bus is driven only during the single ACCESS cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      ram_ce_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_be_o    = 4'd0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (state == S_ACCESS) begin
         ram_ce_o    = 1'b1;
         ram_we_o    = lat_we;
         ram_be_o    = lat_be;
         ram_addr_o  = lat_addr;
         ram_wdata_o = lat_wdata;
      end
   end

   // Completion pulses decode straight from registered state, so stalls drop
   // in the same cycle as the pulse.
   assign if_valid_o     = (state == S_RESP) && (owner == OWN_IF);
   assign mem_valid_o    = (state == S_RESP) && (owner == OWN_MEM);
   assign if_rdata_o     = if_rdata_q;
   assign mem_rdata_o    = mem_rdata_q;
   assign stallreq_if_o  = if_req_i & ~if_valid_o;
   assign stallreq_mem_o = mem_req_i & ~mem_valid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A transaction-level model decides
// grants and completion cycles from the arbitration rules; a behavioural RAM
// answers exactly RAM_LATENCY cycles after each read strobe and returns junk
// otherwise. Directed sequences pin the model with literal expectations, then
// random traffic runs against it.
module tb_mem_port_arbiter;

   localparam int LAT   = 3;
   localparam int LIMIT = 2;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_valid_o;
   logic [31:0] if_rdata_o;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [3:0]  mem_be_i;
   logic        mem_valid_o;
   logic [31:0] mem_rdata_o;
   logic        ram_ce_o;
   logic        ram_we_o;
   logic [3:0]  ram_be_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic [31:0] ram_rdata_i;
   logic        stallreq_if_o;
   logic        stallreq_mem_o;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .RAM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .mem_be_i(mem_be_i),
      .mem_valid_o(mem_valid_o), .mem_rdata_o(mem_rdata_o),
      .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
      .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
      .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;

   // behavioural RAM
   logic [31:0] ram_mem [bit [31:0]];
   int          due_cyc  = -1;
   logic [31:0] due_data = '0;

   // transaction-level model
   bit          t_act = 0;
   bit          t_mem, t_we;
   logic [31:0] t_addr, t_wdata, t_rd;
   logic [3:0]  t_be;
   int          t_g, t_d;
   int          starve = 0;
   logic [31:0] e_if_rd = '0, e_mem_rd = '0;
   bit          e_if_valid = 0, e_mem_valid = 0;

   // samples of the DUT taken at the falling edge
   logic        s_ce, s_we, s_if_valid, s_mem_valid, s_stall_if, s_stall_mem;
   logic [3:0]  s_be;
   logic [31:0] s_addr, s_wdata, s_if_rd, s_mem_rd;

   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      if (ram_mem.exists(a)) return ram_mem[a];
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Grant decision for the current cycle, from the arbitration rules.
   task automatic model_eval();
      bit pick_mem;
      if (rst_i) begin
         t_act    = 0;
         e_if_rd  = '0;
         e_mem_rd = '0;
         starve   = 0;
         return;
      end
      if (t_act && cyc > t_d) t_act = 0;
      if (!t_act && (if_req_i || mem_req_i)) begin
         pick_mem = mem_req_i;
`ifdef MEM_ARB_FAIR_EN
         if (if_req_i && mem_req_i && starve == LIMIT) pick_mem = 0;
         starve = (pick_mem && if_req_i) ? starve + 1 : 0;
`endif
         t_act   = 1;
         t_mem   = pick_mem;
         t_g     = cyc;
         t_we    = pick_mem & mem_we_i;
         t_addr  = pick_mem ? mem_addr_i : if_addr_i;
         t_wdata = mem_wdata_i;
         t_be    = pick_mem ? mem_be_i : 4'd0;
         t_d     = cyc + (t_we ? 2 : LAT + 2);
         t_rd    = t_we ? 32'd0 : ram_rd(t_addr);
      end
   endtask

   task automatic compare();
      bit exp_ce;
      exp_ce      = t_act && (cyc == t_g + 1);
      e_if_valid  = t_act && !t_mem && (cyc == t_d);
      e_mem_valid = t_act && t_mem && (cyc == t_d);
      if (e_if_valid)  e_if_rd  = t_rd;
      if (e_mem_valid) e_mem_rd = t_rd;
      check("ram_ce", 32'(s_ce), 32'(exp_ce));
      check("ram_we", 32'(s_we), 32'(exp_ce && t_we));
      check("ram_be", 32'(s_be), exp_ce ? 32'(t_be) : 32'd0);
      check("ram_addr", s_addr, exp_ce ? t_addr : 32'd0);
      if (!exp_ce || t_mem) check("ram_wdata", s_wdata, exp_ce ? t_wdata : 32'd0);
      check("if_valid", 32'(s_if_valid), 32'(e_if_valid));
      check("mem_valid", 32'(s_mem_valid), 32'(e_mem_valid));
      check("if_rdata", s_if_rd, e_if_rd);
      check("mem_rdata", s_mem_rd, e_mem_rd);
      check("stall_if", 32'(s_stall_if), 32'(if_req_i && !e_if_valid));
      check("stall_mem", 32'(s_stall_mem), 32'(mem_req_i && !e_mem_valid));
   endtask

   // One clock cycle: model, sample/compare, RAM response, advance.
   task automatic cycle();
      model_eval();
      @(negedge clk);
      s_ce = ram_ce_o; s_we = ram_we_o; s_be = ram_be_o;
      s_addr = ram_addr_o; s_wdata = ram_wdata_o;
      s_if_valid = if_valid_o; s_mem_valid = mem_valid_o;
      s_if_rd = if_rdata_o; s_mem_rd = mem_rdata_o;
      s_stall_if = stallreq_if_o; s_stall_mem = stallreq_mem_o;
      compare();
      if (s_ce) begin
         if (s_we) begin
            logic [31:0] old;
            old = ram_rd(s_addr);
            for (int b = 0; b < 4; b++)
               if (s_be[b]) old[8*b +: 8] = s_wdata[8*b +: 8];
            ram_mem[s_addr] = old;
         end else begin
            due_cyc  = cyc + LAT;
            due_data = ram_rd(s_addr);
         end
      end
      ram_rdata_i = (cyc == due_cyc) ? due_data : $urandom();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [31:0] rand_addr();
      return 32'h1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
   endfunction

   int          n_done;
   logic [5:0]  seq;
   bit          stall_dropped;
   int          pulses;
   bit          allow_new;

   initial begin
      rst_i = 1'b1;
      if_req_i = 0; if_addr_i = '0;
      mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_be_i = '0;
      ram_rdata_i = '0;
      ram_mem[32'h100]  = 32'h0000_0013;
      ram_mem[32'h2004] = 32'h0000_0055;
      @(posedge clk);
      #1;
      repeat (3) cycle();
      check("reset_ram_ce", 32'(s_ce), 32'd0);
      check("reset_if_valid", 32'(s_if_valid), 32'd0);
      check("reset_mem_rdata", s_mem_rd, 32'd0);
      rst_i = 1'b0;
      cycle();

      // IF fetch of 0x100
      if_req_i = 1; if_addr_i = 32'h100;
      cycle();
      check("fetch_stall_c0", 32'(s_stall_if), 32'd1);
      cycle();
      check("fetch_ce_c1", 32'(s_ce), 32'd1);
      check("fetch_addr_c1", s_addr, 32'h100);
      repeat (3) cycle();
      check("fetch_no_valid_c4", 32'(s_if_valid), 32'd0);
      cycle();
      check("fetch_valid", 32'(s_if_valid), 32'd1);
      check("fetch_rdata", s_if_rd, 32'h0000_0013);
      check("fetch_stall_drop", 32'(s_stall_if), 32'd0);
      if_req_i = 0;
      cycle();

      // MEM store
      mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h2000;
      mem_wdata_i = 32'hDEAD_BEEF; mem_be_i = 4'b0011;
      cycle();
      cycle();
      check("store_we", 32'(s_we), 32'd1);
      check("store_be", 32'(s_be), 32'b0011);
      cycle();
      check("store_valid", 32'(s_mem_valid), 32'd1);
      check("store_rdata", s_mem_rd, 32'd0);
      mem_req_i = 0; mem_we_i = 0; mem_be_i = 4'd0;
      cycle();

      // Simultaneous requests: MEM load served first
      mem_req_i = 1; mem_addr_i = 32'h2004;
      if_req_i = 1; if_addr_i = 32'h104;
      repeat (6) cycle();
      check("tie_mem_valid", 32'(s_mem_valid), 32'd1);
      check("tie_mem_rdata", s_mem_rd, 32'h0000_0055);
      check("tie_if_waits", 32'(s_if_valid), 32'd0);
      mem_req_i = 0;
      cycle();
      cycle();
      check("tie_if_ce", 32'(s_ce), 32'd1);
      check("tie_if_addr", s_addr, 32'h104);
      repeat (4) cycle();
      check("tie_if_valid", 32'(s_if_valid), 32'd1);
      if_req_i = 0;
      cycle();

      // Reset while an IF read sits in WAIT
      if_req_i = 1; if_addr_i = 32'h300;
      repeat (3) cycle();
      rst_i = 1'b1; if_req_i = 0;
      #1;
      check("rst_async_if_rdata", if_rdata_o, 32'd0);
      check("rst_async_mem_rdata", mem_rdata_o, 32'd0);
      check("rst_async_if_valid", 32'(if_valid_o), 32'd0);
      check("rst_async_ram_addr", ram_addr_o, 32'd0);
      repeat (2) cycle();
      rst_i = 1'b0;
      pulses = 0;
      repeat (8) begin
         cycle();
         if (s_if_valid || s_ce) pulses++;
      end
      check("rst_dropped_access", 32'(pulses), 32'd0);

      // Both requesters held high continuously
      mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h2004;
      if_req_i = 1; if_addr_i = 32'h100;
      n_done = 0; seq = '0; stall_dropped = 0;
      for (int i = 0; i < 120 && n_done < 6; i++) begin
         cycle();
         if (s_mem_valid) begin seq = {seq[4:0], 1'b1}; n_done++; end
         if (s_if_valid)  begin seq = {seq[4:0], 1'b0}; n_done++; end
         if (!s_stall_if) stall_dropped = 1;
      end
      mem_req_i = 0; if_req_i = 0;
      check("contend_done", 32'(n_done), 32'd6);
`ifdef MEM_ARB_FAIR_EN
      check("contend_order", 32'(seq), 32'b110110);
      check("contend_if_stall_drop", 32'(stall_dropped), 32'd1);
`else
      check("contend_order", 32'(seq), 32'b111111);
      check("contend_if_stall_drop", 32'(stall_dropped), 32'd0);
`endif
      repeat (2) cycle();

      // Random traffic, then drain
      allow_new = 1;
      for (int i = 0; i < 1560; i++) begin
         if (i == 1500) allow_new = 0;
         cycle();
         if (if_req_i && e_if_valid) if_req_i = 0;
         if (mem_req_i && e_mem_valid) begin mem_req_i = 0; mem_we_i = 0; end
         if (if_req_i && $urandom_range(0, 7) == 0) if_addr_i = rand_addr();
         if (mem_req_i && $urandom_range(0, 7) == 0) mem_addr_i = rand_addr();
         if (allow_new && !if_req_i && $urandom_range(0, 2) == 0) begin
            if_req_i = 1; if_addr_i = rand_addr();
         end
         if (allow_new && !mem_req_i && $urandom_range(0, 2) == 0) begin
            mem_req_i   = 1;
            mem_we_i    = 1'($urandom_range(0, 1));
            mem_addr_i  = rand_addr();
            mem_wdata_i = $urandom();
            mem_be_i    = 4'($urandom_range(0, 15));
         end
      end
      check("drain_if_idle", 32'(if_req_i), 32'd0);
      check("drain_mem_idle", 32'(mem_req_i), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
